// File: rtl/srm_pkg.sv
// Shared definitions for the Simple RISC Machine controller:
// FSM states, instruction classes and opcode/bus encodings.
package srm_pkg;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPD,
        S_DEC,
        S_GA,
        S_GB,
        S_EX,
        S_WR,
        S_AD,
        S_DA,
        S_RD,
        S_LW,
        S_SB,
        S_SX,
        S_WM,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_MOVI,
        C_MOVR,
        C_ALU,
        C_LDR,
        C_STR,
        C_HALT,
        C_ILL
    } iclass_t;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_MDATA = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_PC    = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/srm_ctrl_core_decode.sv
// Combinational instruction decoder: classifies the IR and
// extracts register fields and sign-extended immediates.
module srm_decode
    import srm_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [15:0]       ir,
    output iclass_t           cls,
    output logic [1:0]        op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [2:0]        rm,
    output logic [1:0]        sh,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5
);

    logic [2:0] opc;

    assign opc    = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = DATA_W'($signed(ir[7:0]));
    assign sximm5 = DATA_W'($signed(ir[4:0]));

    // Map opcode/op pairs to an instruction class; unknown is illegal
    always_comb begin
        cls = C_ILL;
        case (opc)
            OPC_MOV: begin
                if (op == OP_MOVI) begin
                    cls = C_MOVI;
                end else if (op == OP_MOVR) begin
                    cls = C_MOVR;
                end
            end
            OPC_ALU: cls = C_ALU;
            OPC_LDR: if (op == OP_MEM) cls = C_LDR;
            OPC_STR: if (op == OP_MEM) cls = C_STR;
            OPC_HALT: if (op == OP_MEM) cls = C_HALT;
            default: cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/srm_ctrl_core.sv
// Simple RISC Machine control unit: PC, IR, data-address
// register and the multi-cycle FSM sequencing the datapath.
module srm_ctrl_core
    import srm_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] dp_out,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              write,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        vsel,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] pc_out,
    output logic              halted,
    output logic              illegal
);

    state_t            state;
    state_t            next;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] dar;

    iclass_t    cls;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;

    logic unused_dp;

    // Only the low address bits of the datapath result form an address
    assign unused_dp = ^dp_out[DATA_W-1:ADDR_W];

    assign pc_out = DATA_W'(pc);

    srm_decode #(
        .DATA_W(DATA_W)
    ) u_decode (
        .ir    (ir),
        .cls   (cls),
        .op    (op),
        .rn    (rn),
        .rd    (rd),
        .rm    (rm),
        .sh    (sh),
        .sximm8(sximm8),
        .sximm5(sximm5)
    );

    // FSM state register; reset abandons any pending memory command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RST;
        end else begin
            state <= next;
        end
    end

    // PC, IR and data-address register updates keyed on FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= ADDR_W'(RESET_PC);
            ir  <= '0;
            dar <= '0;
        end else begin
            case (state)
                S_IF2: ir <= mem_rdata[15:0];
                S_UPD: pc <= pc + ADDR_W'(1);
                S_DA:  dar <= dp_out[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    // Next-state logic and single-cycle strobes decoded from state
    always_comb begin
        next     = state;
        mem_cmd  = CMD_NONE;
        mem_addr = pc;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        readnum  = 3'd0;
        writenum = 3'd0;
        shift    = 2'b00;
        ALUop    = ALU_ADD;
        halted   = 1'b0;
        illegal  = 1'b0;
        unique case (state)
            S_RST: next = S_IF1;
            S_IF1: begin
                mem_cmd = CMD_READ;
                if (mem_ready) next = S_IF2;
            end
            S_IF2: next = S_UPD;
            S_UPD: next = S_DEC;
            S_DEC: begin
                case (cls)
                    C_MOVI: next = S_WR;
                    C_MOVR: next = S_GB;
                    C_ALU:  next = S_GA;
                    C_LDR:  next = S_GA;
                    C_STR:  next = S_GA;
                    C_HALT: next = S_HALT;
                    default: begin
                        illegal = 1'b1;
                        next    = S_IF1;
                    end
                endcase
            end
            S_GA: begin
                readnum = rn;
                loada   = 1'b1;
                next    = (cls == C_ALU) ? S_GB : S_AD;
            end
            S_GB: begin
                readnum = rm;
                loadb   = 1'b1;
                next    = S_EX;
            end
            S_EX: begin
                shift = sh;
                if (cls == C_MOVR) begin
                    asel  = 1'b1;
                    loadc = 1'b1;
                    next  = S_WR;
                end else if (op == OP_CMP) begin
                    ALUop = op;
                    loads = 1'b1;
                    next  = S_IF1;
                end else begin
                    ALUop = op;
                    loadc = 1'b1;
                    next  = S_WR;
                end
            end
            S_WR: begin
                write = 1'b1;
                if (cls == C_MOVI) begin
                    vsel     = VSEL_IMM8;
                    writenum = rn;
                end else begin
                    writenum = rd;
                end
                next = S_IF1;
            end
            S_AD: begin
                bsel  = 1'b1;
                loadc = 1'b1;
                next  = S_DA;
            end
            S_DA: next = (cls == C_LDR) ? S_RD : S_SB;
            S_RD: begin
                mem_cmd  = CMD_READ;
                mem_addr = dar;
                if (mem_ready) next = S_LW;
            end
            S_LW: begin
                vsel     = VSEL_MDATA;
                write    = 1'b1;
                writenum = rd;
                next     = S_IF1;
            end
            S_SB: begin
                readnum = rd;
                loadb   = 1'b1;
                next    = S_SX;
            end
            S_SX: begin
                asel  = 1'b1;
                loadc = 1'b1;
                next  = S_WM;
            end
            S_WM: begin
                mem_cmd  = CMD_WRITE;
                mem_addr = dar;
                if (mem_ready) next = S_IF1;
            end
            S_HALT: halted = 1'b1;
            default: next = S_RST;
        endcase
    end

endmodule
